// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: synchronised rx line, 3-sample majority vote per bit,
// false-start rejection, optional parity and 1 or 2 checked stop bits.
module uart_rx_oversampled #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  baud_tick,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error,
  output logic                  busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_n;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    rxs;
  logic [TW-1:0]           tick_cnt, tick_n, idx;
  logic [BW-1:0]           bit_cnt, bit_n;
  logic                    s0, s0_n, s1, s1_n, vote;
  logic [DATA_WIDTH-1:0]   shreg, shreg_n;
  logic                    perr, perr_n, stop_acc, stop_n;
  logic                    pen, pen_n, ptyp, ptyp_n;
  logic                    fin, fin_n;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign rxs  = sync[SYNC_STAGES-1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[SYNC_STAGES-2:0], rx_in};
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    s0_n    = s0;
    s1_n    = s1;
    shreg_n = shreg;
    perr_n  = perr;
    stop_n  = stop_acc;
    pen_n   = pen;
    ptyp_n  = ptyp;
    fin_n   = 1'b0;
    // idx is the position of the current tick within the bit; the start-detect tick is 0
    idx     = (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
    vote    = maj3(s0, s1, rxs);
    if (baud_tick) begin
      if (state == IDLE) begin
        if (!rxs) begin
          state_n = START;
          tick_n  = '0;
          bit_n   = '0;
          perr_n  = 1'b0;
          stop_n  = 1'b0;
          pen_n   = par_en;
          ptyp_n  = par_typ;
        end
      end else begin
        tick_n = idx;
        if (idx == T_S0) s0_n = rxs;
        if (idx == T_S1) s1_n = rxs;
        unique case (state)
          START: begin
            if (idx == T_VOTE && vote) state_n = IDLE;
            else if (idx == T_LAST)    state_n = DATA;
          end
          DATA: begin
            if (idx == T_VOTE) shreg_n = {vote, shreg[DATA_WIDTH-1:1]};
            if (idx == T_LAST) begin
              if (bit_cnt == B_LAST) begin
                bit_n   = '0;
                state_n = pen ? PARITY : STOP;
              end else begin
                bit_n = bit_cnt + 1'b1;
              end
            end
          end
          PARITY: begin
            if (idx == T_VOTE) perr_n = ptyp ? ~^{shreg, vote} : ^{shreg, vote};
            if (idx == T_LAST) state_n = STOP;
          end
          STOP: begin
            // leave on the final stop vote so a start bit right after it is not missed
            if (idx == T_VOTE) begin
              stop_n = stop_acc | ~vote;
              if (bit_cnt == S_LAST) begin
                state_n = IDLE;
                fin_n   = 1'b1;
              end
            end
            if (idx == T_LAST) bit_n = bit_cnt + 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      perr       <= 1'b0;
      stop_acc   <= 1'b0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      fin        <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_error  <= 1'b0;
      stop_error <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      s0         <= s0_n;
      s1         <= s1_n;
      shreg      <= shreg_n;
      perr       <= perr_n;
      stop_acc   <= stop_n;
      pen        <= pen_n;
      ptyp       <= ptyp_n;
      fin        <= fin_n;
      data_valid <= fin;
      if (fin) begin
        p_data     <= shreg;
        par_error  <= perr;
        stop_error <= stop_acc;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: two instances (8N1 and 9-bit/2-stop) fed with
// directed and random frames; a queue of expected frames is checked on each data_valid.
module tb_uart_rx_oversampled;
  localparam int OS = 16;

  logic clk = 1'b0, rst = 1'b0, baud_tick = 1'b0;
  logic par_en = 1'b0, par_typ = 1'b0, rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] pd_a;
  logic [8:0] pd_b;
  logic dv_a, pe_a, se_a, busy_a, dv_b, pe_b, se_b, busy_b;
  int total = 0, bad = 0;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       se;
  } exp_t;
  exp_t q_a[$], q_b[$];

  uart_rx_oversampled #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a), .baud_tick(baud_tick), .par_en(par_en), .par_typ(par_typ),
    .p_data(pd_a), .data_valid(dv_a), .par_error(pe_a), .stop_error(se_a), .busy(busy_a));

  uart_rx_oversampled #(.DATA_WIDTH(9), .OVERSAMPLE(OS), .STOP_BITS(2), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .rx_in(rx_b), .baud_tick(baud_tick), .par_en(par_en), .par_typ(par_typ),
    .p_data(pd_b), .data_valid(dv_b), .par_error(pe_b), .stop_error(se_b), .busy(busy_b));

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (dv_a) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_data", {24'd0, pd_a}, {23'd0, e.d});
        check("a_par_error", {31'd0, pe_a}, {31'd0, e.pe});
        check("a_stop_error", {31'd0, se_a}, {31'd0, e.se});
        check("a_busy_at_valid", {31'd0, busy_a}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (dv_b) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_data", {23'd0, pd_b}, {23'd0, e.d});
        check("b_par_error", {31'd0, pe_b}, {31'd0, e.pe});
        check("b_stop_error", {31'd0, se_b}, {31'd0, e.se});
        check("b_busy_at_valid", {31'd0, busy_b}, 32'd0);
      end
    end
  end

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  task automatic idle(input int which, input int nbits);
    drive(which, 1'b1);
    tick_wait(nbits * OS);
  endtask

  // Builds the line waveform of one frame; the expected result comes from the frame rules.
  task automatic send(input int which, input logic [8:0] d, input int w, input int s,
                      input logic pe, input logic pt, input logic pflip, input logic [1:0] stopv,
                      input int abort_bit, input int spike_bit);
    logic [15:0] line;
    int n, ones;
    logic pbit;
    exp_t e;
    line = '1;
    line[0] = 1'b0;
    ones = 0;
    e.d = '0;
    for (int i = 0; i < w; i++) begin
      line[1+i] = d[i];
      e.d[i] = d[i];
      ones += d[i] ? 1 : 0;
    end
    n = 1 + w;
    pbit = 1'b0;
    if (pe) begin
      pbit = ((ones % 2) != 0) ^ pt ^ pflip;
      line[n] = pbit;
      n++;
    end
    e.pe = pe ? (((ones + (pbit ? 1 : 0)) % 2) != (pt ? 1 : 0)) : 1'b0;
    e.se = 1'b0;
    for (int k = 0; k < s; k++) begin
      line[n] = stopv[k];
      if (!stopv[k]) e.se = 1'b1;
      n++;
    end
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
    par_en  = pe;
    par_typ = pt;
    for (int b = 0; b < n; b++) begin
      drive(which, line[b]);
      if (pe && b == 1 + w) par_typ = ~pt;
      if (b == abort_bit) begin
        tick_wait(8);
        rst = 1'b0;
        drive(which, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        if (which == 0) void'(q_a.pop_back());
        else            void'(q_b.pop_back());
        return;
      end
      if (b == spike_bit && line[b]) begin
        tick_wait(8);
        drive(which, 1'b0);
        tick_wait(1);
        drive(which, 1'b1);
        tick_wait(OS - 9);
      end else begin
        tick_wait(OS);
      end
    end
  endtask

  initial begin
    logic [8:0] rd;
    logic [1:0] sv;
    logic rpe, rpt, rpf;
    int gap;

    // reset with the line held low
    rx_a = 1'b0;
    rx_b = 1'b0;
    rst  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, dv_a}, 32'd0);
    check("rst_data", {24'd0, pd_a}, 32'd0);
    check("rst_par_error", {31'd0, pe_a}, 32'd0);
    check("rst_stop_error", {31'd0, se_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    rx_a = 1'b1;
    rx_b = 1'b1;
    rst  = 1'b1;
    tick_wait(2 * OS);
    check("idle_after_release", {31'd0, busy_a}, 32'd0);

    // plain 8N1
    send(0, 9'h0A5, 8, 1, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1);
    idle(0, 2);
    check("a5_received", q_a.size(), 32'd0);

    // even parity, correct then wrong parity bit
    send(0, 9'h007, 8, 1, 1'b1, 1'b0, 1'b0, 2'b11, -1, -1);
    idle(0, 1);
    send(0, 9'h007, 8, 1, 1'b1, 1'b0, 1'b1, 2'b11, -1, -1);
    idle(0, 2);
    check("parity_received", q_a.size(), 32'd0);

    // short low glitch is a false start
    drive(0, 1'b0);
    tick_wait(4);
    drive(0, 1'b1);
    tick_wait(OS - 4);
    check("glitch_busy", {31'd0, busy_a}, 32'd0);
    idle(0, 1);
    // one-tick spike inside data bit 0 (value 1)
    send(0, 9'h055, 8, 1, 1'b0, 1'b0, 1'b0, 2'b11, -1, 1);
    idle(0, 2);
    check("spike_received", q_a.size(), 32'd0);

    // stop error, then next frame with no idle gap
    send(0, 9'h03C, 8, 1, 1'b0, 1'b0, 1'b0, 2'b00, -1, -1);
    send(0, 9'h0C3, 8, 1, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1);
    idle(0, 2);
    check("b2b_received", q_a.size(), 32'd0);

    // reset during data bit 4, then a clean frame
    send(0, 9'h096, 8, 1, 1'b0, 1'b0, 1'b0, 2'b11, 5, -1);
    check("abort_data", {24'd0, pd_a}, 32'd0);
    check("abort_stop_error", {31'd0, se_a}, 32'd0);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    idle(0, 2);
    check("abort_no_valid", {31'd0, dv_a}, 32'd0);
    send(0, 9'h055, 8, 1, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1);
    idle(0, 2);
    send(1, 9'h1AB, 9, 2, 1'b0, 1'b0, 1'b0, 2'b11, 5, -1);
    check("abort_b_data", {23'd0, pd_b}, 32'd0);
    check("abort_b_busy", {31'd0, busy_b}, 32'd0);
    idle(1, 2);
    send(1, 9'h1AB, 9, 2, 1'b0, 1'b0, 1'b0, 2'b11, -1, -1);
    idle(1, 2);
    check("b_1ab_received", q_b.size(), 32'd0);

    // random frames on both instances
    for (int i = 0; i < 16; i++) begin
      rd  = 9'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      rpf = 1'($urandom);
      sv  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      gap = $urandom_range(0, 2);
      if (i < 10) begin
        if (!sv[0] && gap == 0) gap = 1;
        send(0, rd, 8, 1, rpe, rpt, rpf, sv, -1, -1);
        if (gap > 0) idle(0, gap);
      end else begin
        if (!sv[1] && gap == 0) gap = 1;
        send(1, rd, 9, 2, rpe, rpt, rpf, sv, -1, -1);
        if (gap > 0) idle(1, gap);
      end
    end
    idle(0, 2);
    idle(1, 1);
    check("a_all_received", q_a.size(), 32'd0);
    check("b_all_received", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
